// File: rtl/ifu_pkg.sv
// Shared encodings for the front end: fetch FSM states, reset vector,
// instruction-type and ALU operation codes used by decode/execute.
package ifu_pkg;

  // First fetch address after reset unless the instantiating design overrides it.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Fetch FSM: issue request, wait for the response, hold the word for decode.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  // Instruction formats, resolved downstream from the opcode field.
  typedef enum logic [2:0] {
    INST_R = 3'd0,
    INST_I = 3'd1,
    INST_S = 3'd2,
    INST_B = 3'd3,
    INST_U = 3'd4,
    INST_J = 3'd5
  } inst_type_e;

  // ALU operations selected by decode from funct3/funct7.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Fetches are always word-aligned; low address bits of a target are ignored.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory request at a time, a single
// holding register toward decode, and redirect handling that discards any
// response belonging to a fetch issued before the redirect.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_cnt
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;

  // Next-state logic; a redirect always wins over sequential advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = word_align(redirect_pc);
          // Request accepted this cycle belongs to the old path: drop its response.
          if (imem_req_ready) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = word_align(redirect_pc);
          if (imem_rsp_valid) begin
            // Stale response arrives together with the redirect: discard now.
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // An instruction consumed in the same cycle as a redirect still counts.
        if (out_ready) begin
          cnt_d = cnt_q + 32'd1;
        end
        if (redirect_valid) begin
          pc_d    = word_align(redirect_pc);
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset abandons any in-flight fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs are gated by reset so nothing is issued or delivered during it.
  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = rst_n && (state_q == S_HOLD);
  assign out_inst       = inst_q;
  assign out_pc         = pc_q;
  assign fetch_cnt      = cnt_q;

endmodule
